// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Blanking between digits is compiled in with SEG7_SCAN_BLANK_EN.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Frame write handshake between the digit-value producer and the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    logic                            wr_valid;
    logic                            wr_ready;
    logic [NUM_DIGITS*DIGIT_W-1:0]   wr_data;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/seg7_scan_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded interval.
// expire_nxt is the value expire takes next cycle, so callers can register in lockstep.
module seg7_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire,
    output logic         expire_nxt
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         exp_q;

    // A load of 0 parks the counter; it saturates at 0 and never wraps.
    always_comb begin
        cnt_d      = cnt_q;
        expire_nxt = 1'b0;
        if (load) begin
            cnt_d      = (load_val == '0) ? '0 : load_val - W'(1);
            expire_nxt = (load_val == W'(1));
        end else if (cnt_q != '0) begin
            cnt_d      = cnt_q - W'(1);
            expire_nxt = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= expire_nxt;
        end
    end

    assign expire = exp_q;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-atomic display updates.
// Define SEG7_SCAN_BLANK_EN to insert a dark interval after every digit.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL        = 10_000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    seg7_scan_ctrl_if.slave       wr,
    output logic [DIGIT_W-1:0]    digit_code,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(max2(DWELL, BLANK_CYCLES) + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_SHOW  = 2'(SHOW);
`ifdef SEG7_SCAN_BLANK_EN
    localparam logic [1:0] S_BLANK = 2'(BLANK);
`endif

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    frame_t                shadow_q, shadow_d, pend_q, pend_d;
    logic                  pfull_q, pfull_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [DIGIT_W-1:0]    code_q, code_d;
    logic                  fd_q, fd_d;

    logic          load, expire, expire_nxt, adv, swap, last_phase;
    logic [PW-1:0] load_val;

    seg7_scan_timer #(.W(PW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .expire     (expire),
        .expire_nxt (expire_nxt)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        pfull_d  = pfull_q;
        sel_d    = '0;
        code_d   = code_q;
        load     = 1'b0;
        load_val = '0;
        adv      = 1'b0;
        swap     = 1'b0;

        // Disable parks the prescaler at 0 and restarts the frame on re-enable.
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            load    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SHOW;
                    idx_d    = '0;
                    load     = 1'b1;
                    load_val = PW'(DWELL);
                    swap     = pfull_q;
                end
                S_SHOW: if (expire) begin
`ifdef SEG7_SCAN_BLANK_EN
                    state_d  = S_BLANK;
                    load     = 1'b1;
                    load_val = PW'(BLANK_CYCLES);
`else
                    adv      = 1'b1;
`endif
                end
`ifdef SEG7_SCAN_BLANK_EN
                S_BLANK: if (expire) adv = 1'b1;
`endif
                default: state_d = S_IDLE;
            endcase

            if (adv) begin
                state_d  = S_SHOW;
                load     = 1'b1;
                load_val = PW'(DWELL);
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    swap  = pfull_q;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
        end

        if (swap) begin
            shadow_d = pend_q;
            pfull_d  = 1'b0;
        end
        // Accept only on the pre-edge ready, so a boundary swap always wins.
        if (wr.wr_valid && !pfull_q) begin
            pend_d  = wr.wr_data;
            pfull_d = 1'b1;
        end

        if (state_d == S_SHOW) begin
            sel_d[idx_d] = 1'b1;
            code_d       = shadow_d[idx_d];
        end

`ifdef SEG7_SCAN_BLANK_EN
        last_phase = (state_d == S_BLANK);
`else
        last_phase = (state_d == S_SHOW);
`endif
        fd_d = last_phase && (idx_d == LAST_IDX) && expire_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            pend_q   <= '0;
            pfull_q  <= 1'b0;
            sel_q    <= '0;
            code_q   <= BLANK_CODE;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pfull_q  <= pfull_d;
            sel_q    <= sel_d;
            code_q   <= code_d;
            fd_q     <= fd_d;
        end
    end

    assign wr.wr_ready = !pfull_q;
    assign digit_sel   = sel_q;
    assign digit_code  = code_q;
    assign frame_done  = fd_q;
endmodule
